// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback,
// with MemReady stalls and illegal-encoding detection (illegal instructions retire as NOPs).
module multicycle_controller #(
  parameter int ALUCTRL_W    = 3,
  parameter bit SUPPORT_ADDI = 1'b1,
  parameter bit SUPPORT_J    = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           OP,
  input  logic [5:0]           Funct,
  input  logic                 Zero,
  input  logic                 MemReady,
  output logic                 IorD,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegDst,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           PCSrc,
  output logic                 PCEn,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 Illegal,
  output logic [3:0]           State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       w_iord, w_memwrite, w_irwrite, w_regdst, w_memtoreg, w_regwrite;
  logic       w_alusrca, w_pcwrite, w_branch, w_illegal;
  logic [1:0] w_alusrcb, w_pcsrc, w_aluop;
  logic [2:0] w_alu;

  // Unsupported opcodes map to FETCH, which doubles as the illegal-opcode indication.
  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      6'b100011, 6'b101011: decode_next = S_MEMADR;
      6'b000000:            decode_next = S_EXECUTE;
      6'b000100:            decode_next = S_BRANCH;
      6'b001000:            decode_next = SUPPORT_ADDI ? S_ADDIEX : S_FETCH;
      6'b000010:            decode_next = SUPPORT_J ? S_JUMP : S_FETCH;
      default:              decode_next = S_FETCH;
    endcase
  endfunction

  function automatic logic funct_known(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_known = 1'b1;
      default:                                               funct_known = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default:   funct_alu = 3'b010;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = MemReady ? S_DECODE : S_FETCH;
      S_DECODE:   w_next = decode_next(OP);
      S_MEMADR:   w_next = (OP == 6'b100011) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: w_next = MemReady ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  w_next = funct_known(Funct) ? S_ALUWB : S_FETCH;
      S_ADDIEX:   w_next = S_ADDIWB;
      default:    w_next = S_FETCH;
    endcase
  end

  // Moore output decode; only FETCH (MemReady) and the illegal checks look at inputs
  always_comb begin
    w_iord     = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_pcsrc    = 2'b00;
    w_aluop    = 2'b00;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_alusrcb = 2'b01;
        w_irwrite = MemReady;
        w_pcwrite = MemReady;
      end
      S_DECODE: begin
        w_alusrcb = 2'b11;
        w_illegal = (decode_next(OP) == S_FETCH);
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      S_MEMREAD:  w_iord = 1'b1;
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWRITE: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECUTE: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
        w_illegal = ~funct_known(Funct);
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BRANCH: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b01;
        w_pcsrc   = 2'b01;
        w_branch  = 1'b1;
      end
      S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      S_ADDIWB:   w_regwrite = 1'b1;
      S_JUMP: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
      end
      default:    w_iord = 1'b0;
    endcase
  end

  // ALU control from ALUOp and Funct
  always_comb begin
    w_alu = 3'b010;
    case (w_aluop)
      2'b01:   w_alu = 3'b110;
      2'b10:   w_alu = funct_alu(Funct);
      default: w_alu = 3'b010;
    endcase
  end

  // Write enables are suppressed while reset is sampled so an abandoned instruction cannot commit.
  assign IorD       = w_iord;
  assign MemWrite   = w_memwrite & ~reset;
  assign IRWrite    = w_irwrite & ~reset;
  assign RegDst     = w_regdst;
  assign MemtoReg   = w_memtoreg;
  assign RegWrite   = w_regwrite & ~reset;
  assign ALUSrcA    = w_alusrca;
  assign ALUSrcB    = w_alusrcb;
  assign PCSrc      = w_pcsrc;
  assign PCEn       = (w_pcwrite | (w_branch & Zero)) & ~reset;
  assign ALUControl = ALUCTRL_W'(w_alu);
  assign Illegal    = w_illegal & ~reset;
  assign State      = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller; expected per-instruction state
// sequences are built from the instruction class and stall counts, outputs from the state table.
module tb_multicycle_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, Zero, MemReady;
  logic [5:0] OP, Funct;

  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, Illegal;
  logic [1:0] ALUSrcB, PCSrc;
  logic [4:0] ALUControl;
  logic [3:0] State;

  logic       nj_IorD, nj_MemWrite, nj_IRWrite, nj_RegDst, nj_MemtoReg, nj_RegWrite;
  logic       nj_ALUSrcA, nj_PCEn, nj_Illegal;
  logic [1:0] nj_ALUSrcB, nj_PCSrc;
  logic [2:0] nj_ALUControl;
  logic [3:0] nj_State;

  multicycle_controller #(.ALUCTRL_W(5), .SUPPORT_ADDI(1'b1), .SUPPORT_J(1'b1)) dut (
    .clk(clk), .reset(reset), .OP(OP), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSrc(PCSrc), .PCEn(PCEn), .ALUControl(ALUControl), .Illegal(Illegal), .State(State)
  );

  multicycle_controller #(.ALUCTRL_W(3), .SUPPORT_ADDI(1'b0), .SUPPORT_J(1'b0)) dut_nj (
    .clk(clk), .reset(reset), .OP(OP), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .IorD(nj_IorD), .MemWrite(nj_MemWrite), .IRWrite(nj_IRWrite), .RegDst(nj_RegDst),
    .MemtoReg(nj_MemtoReg), .RegWrite(nj_RegWrite), .ALUSrcA(nj_ALUSrcA),
    .ALUSrcB(nj_ALUSrcB), .PCSrc(nj_PCSrc), .PCEn(nj_PCEn), .ALUControl(nj_ALUControl),
    .Illegal(nj_Illegal), .State(nj_State)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int s;
    bit mr;
    bit ill;
  } step_t;

  step_t exp_q[$];

  function automatic bit funct_legal(input logic [5:0] f);
    return f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
  endfunction

  function automatic logic [2:0] alu_ref(input logic [5:0] f);
    case (f)
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2a:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  task automatic push(input int s, input bit mr, input bit ill);
    step_t e;
    e.s = s; e.mr = mr; e.ill = ill;
    exp_q.push_back(e);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1; MemReady = 1'b1;
    @(posedge clk); #1;
  endtask

  // Runs one instruction on the main DUT; zmode 0/1 fixes Zero, 2 randomizes it each cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int stall_f, input int stall_m, input int zmode);
    step_t      e;
    bit         z;
    logic [1:0] e_srcb, e_pcsrc;
    logic [11:0] e_ctrl, g_ctrl;
    logic [4:0] e_alu;
    exp_q.delete();
    for (int i = 0; i < stall_f; i++) push(0, 1'b0, 1'b0);
    push(0, 1'b1, 1'b0);
    case (op)
      6'h23: begin
        push(1, 1'b1, 1'b0); push(2, 1'b1, 1'b0);
        for (int i = 0; i < stall_m; i++) push(3, 1'b0, 1'b0);
        push(3, 1'b1, 1'b0); push(4, 1'b1, 1'b0);
      end
      6'h2b: begin
        push(1, 1'b1, 1'b0); push(2, 1'b1, 1'b0);
        for (int i = 0; i < stall_m; i++) push(5, 1'b0, 1'b0);
        push(5, 1'b1, 1'b0);
      end
      6'h00: begin
        push(1, 1'b1, 1'b0);
        if (funct_legal(fn)) begin
          push(6, 1'b1, 1'b0); push(7, 1'b1, 1'b0);
        end else begin
          push(6, 1'b1, 1'b1);
        end
      end
      6'h04: begin push(1, 1'b1, 1'b0); push(8, 1'b1, 1'b0); end
      6'h08: begin push(1, 1'b1, 1'b0); push(9, 1'b1, 1'b0); push(10, 1'b1, 1'b0); end
      6'h02: begin push(1, 1'b1, 1'b0); push(11, 1'b1, 1'b0); end
      default: push(1, 1'b1, 1'b1);
    endcase
    foreach (exp_q[k]) begin
      e = exp_q[k];
      @(posedge clk); #1;
      reset = 1'b0; OP = op; Funct = fn;
      MemReady = (e.s inside {0, 3, 5}) ? e.mr : 1'($urandom_range(0, 1));
      z = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
      Zero = z;
      @(negedge clk);
      e_srcb  = (e.s == 0) ? 2'b01 : (e.s == 1) ? 2'b11 : (e.s inside {2, 9}) ? 2'b10 : 2'b00;
      e_pcsrc = (e.s == 8) ? 2'b01 : (e.s == 11) ? 2'b10 : 2'b00;
      e_ctrl  = {(e.s inside {3, 5}), (e.s == 5), (e.s == 0 && e.mr), (e.s == 7), (e.s == 4),
                 (e.s inside {4, 7, 10}), (e.s inside {2, 6, 8, 9}), e_srcb, e_pcsrc,
                 ((e.s == 0 && e.mr) || e.s == 11 || (e.s == 8 && z))};
      g_ctrl  = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSrc, PCEn};
      e_alu   = {2'b00, (e.s == 6) ? alu_ref(fn) : (e.s == 8) ? 3'b110 : 3'b010};
      n_checks++;
      if (State !== 4'(e.s)) $display("FAIL state op=%h step %0d: got %0d expected %0d", op, k, State, e.s);
      else n_pass++;
      n_checks++;
      if (g_ctrl !== e_ctrl) $display("FAIL ctrl op=%h step %0d: got %b expected %b", op, k, g_ctrl, e_ctrl);
      else n_pass++;
      n_checks++;
      if (ALUControl !== e_alu) $display("FAIL aluctrl op=%h step %0d: got %b expected %b", op, k, ALUControl, e_alu);
      else n_pass++;
      n_checks++;
      if (Illegal !== e.ill) $display("FAIL illegal op=%h step %0d: got %b expected %b", op, k, Illegal, e.ill);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      reset = 1'b1; MemReady = 1'b1; OP = 6'h02; Zero = 1'b1;
      @(negedge clk);
      n_checks++;
      if (State !== 4'd0 || nj_State !== 4'd0) $display("FAIL reset_state: got %0d/%0d expected 0", State, nj_State);
      else n_pass++;
      n_checks++;
      if ({MemWrite, RegWrite, IRWrite, PCEn, Illegal} !== 5'b0)
        $display("FAIL reset_enables: got %b expected 00000", {MemWrite, RegWrite, IRWrite, PCEn, Illegal});
      else n_pass++;
    end
  endtask

  task automatic test_lw();
    run_instr(6'h23, 6'h00, 0, 0, 0);
    run_instr(6'h23, 6'h00, 2, 2, 2);
  endtask

  task automatic test_rtype();
    run_instr(6'h00, 6'h2a, 0, 0, 0);
    run_instr(6'h00, 6'h3f, 0, 0, 0);
    run_instr(6'h00, 6'h22, 1, 0, 2);
  endtask

  task automatic test_sw_stall();
    run_instr(6'h2b, 6'h00, 0, 3, 0);
  endtask

  task automatic test_beq();
    run_instr(6'h04, 6'h00, 0, 0, 1);
    run_instr(6'h04, 6'h00, 0, 0, 0);
  endtask

  task automatic test_jump();
    logic [5:0] ops[2];
    run_instr(6'h02, 6'h00, 0, 0, 0);
    run_instr(6'h08, 6'h20, 0, 0, 0);
    apply_reset();
    ops[0] = 6'h02; ops[1] = 6'h08;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      reset = 1'b0; OP = ops[i]; MemReady = 1'b1; Zero = 1'b1;
      @(negedge clk);
      n_checks++;
      if (nj_State !== 4'd0 || nj_PCEn !== 1'b1 || nj_Illegal !== 1'b0)
        $display("FAIL nj_fetch op=%h: got st=%0d pcen=%b ill=%b expected 0/1/0", ops[i], nj_State, nj_PCEn, nj_Illegal);
      else n_pass++;
      @(posedge clk); #1;
      MemReady = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_checks++;
      if (nj_State !== 4'd1 || nj_PCEn !== 1'b0 || nj_Illegal !== 1'b1)
        $display("FAIL nj_decode op=%h: got st=%0d pcen=%b ill=%b expected 1/0/1", ops[i], nj_State, nj_PCEn, nj_Illegal);
      else n_pass++;
    end
    @(posedge clk); #1;
    MemReady = 1'b0;
    @(negedge clk);
    n_checks++;
    if (nj_State !== 4'd0 || nj_Illegal !== 1'b0 || nj_PCEn !== 1'b0)
      $display("FAIL nj_return: got st=%0d ill=%b pcen=%b expected 0/0/0", nj_State, nj_Illegal, nj_PCEn);
    else n_pass++;
    apply_reset();
  endtask

  task automatic test_reset_mid();
    int st[4];
    st[0] = 0; st[1] = 1; st[2] = 2; st[3] = 5;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      reset = 1'b0; OP = 6'h2b; MemReady = (i == 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      n_checks++;
      if (State !== 4'(st[i])) $display("FAIL mid_seq step %0d: got %0d expected %0d", i, State, st[i]);
      else n_pass++;
    end
    @(posedge clk); #1;
    reset = 1'b1; MemReady = 1'b0;
    @(negedge clk);
    n_checks++;
    if (MemWrite !== 1'b0 || State !== 4'd5)
      $display("FAIL mid_reset_cycle: got mw=%b st=%0d expected 0/5", MemWrite, State);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0; MemReady = 1'b0;
    @(negedge clk);
    n_checks++;
    if (State !== 4'd0 || MemWrite !== 1'b0)
      $display("FAIL mid_after_reset: got st=%0d mw=%b expected 0/0", State, MemWrite);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[8];
    logic [5:0] fns[7];
    ops = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h02, 6'h3f, 6'h11};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h3f};
    for (int n = 0; n < 60; n++) begin
      run_instr(ops[$urandom_range(0, 7)], fns[$urandom_range(0, 6)],
                $urandom_range(0, 2), $urandom_range(0, 2), 2);
    end
    run_instr(6'h04, 6'h00, 0, 0, 2);
  endtask

  initial begin
    reset = 1'b1; OP = 6'h00; Funct = 6'h00; Zero = 1'b0; MemReady = 1'b1;
    test_reset();
    test_lw();
    test_rtype();
    test_sw_stall();
    test_beq();
    test_jump();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
